// File: rtl/coin_pulse_encoder.sv
// Coin validator front end: synchronizes and debounces the raw pulse train, counts
// pulses per coin and strobes a 3-bit coin code (Enable) or a Reject.
module coin_pulse_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 1000,
  parameter int STUCK_CYCLES    = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Pulse_In,
  output logic [2:0] Coin,
  output logic       Enable,
  output logic       Reject,
  output logic       Busy
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam int HI_W  = $clog2(STUCK_CYCLES);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [HI_W-1:0]  HI_LAST  = HI_W'(STUCK_CYCLES - 1);
  localparam logic [HI_W-1:0]  HI_ONE   = HI_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PULSE_HI = 3'd1,
    PULSE_LO = 3'd2,
    EMIT     = 3'd3,
    REJECT   = 3'd4,
    WAIT_LOW = 3'd5
  } state_t;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [HI_W-1:0]  hi_timer_q, hi_timer_d;
  logic [GAP_W-1:0] gap_timer_q, gap_timer_d;
  logic [2:0]       coin_q, coin_d;
  logic             enable_q, enable_d;
  logic             reject_q, reject_d;
  logic             busy_q, busy_d;

  // Synchronizer and debouncer: lvl follows the synced input only after a full run of differing samples.
  always_comb begin
    sync1_d  = Pulse_In;
    sync2_d  = sync1_q;
    lvl_d    = lvl_q;
    db_cnt_d = {DB_W{1'b0}};
    if (sync2_q != lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        lvl_d    = sync2_q;
        db_cnt_d = {DB_W{1'b0}};
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Coin FSM next state; strobes and Coin are computed here so they register with the state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_timer_d  = hi_timer_q;
    gap_timer_d = gap_timer_q;
    coin_d      = coin_q;
    enable_d    = 1'b0;
    reject_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lvl_q) begin
          state_d    = PULSE_HI;
          count_d    = 3'd1;
          hi_timer_d = {HI_W{1'b0}};
        end else begin
          count_d    = 3'd0;
        end
      end
      PULSE_HI: begin
        if (!lvl_q) begin
          state_d     = PULSE_LO;
          gap_timer_d = {GAP_W{1'b0}};
        end else if (hi_timer_q == HI_LAST) begin
          state_d  = REJECT;
          reject_d = 1'b1;
        end else begin
          hi_timer_d = hi_timer_q + HI_ONE;
        end
      end
      PULSE_LO: begin
        if (lvl_q) begin
          state_d    = PULSE_HI;
          count_d    = (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
          hi_timer_d = {HI_W{1'b0}};
        end else if (gap_timer_q == GAP_LAST) begin
          if ((count_q == 3'd1) || (count_q == 3'd5)) begin
            state_d  = EMIT;
            enable_d = 1'b1;
            coin_d   = count_q;
          end else begin
            state_d  = REJECT;
            reject_d = 1'b1;
          end
        end else begin
          gap_timer_d = gap_timer_q + GAP_ONE;
        end
      end
      EMIT: begin
        state_d = IDLE;
        count_d = 3'd0;
      end
      REJECT: begin
        // A still-high input must drop before a new coin can start.
        state_d = lvl_q ? WAIT_LOW : IDLE;
        count_d = 3'd0;
      end
      WAIT_LOW: begin
        if (!lvl_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 3'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      lvl_q       <= 1'b0;
      db_cnt_q    <= {DB_W{1'b0}};
      state_q     <= IDLE;
      count_q     <= 3'd0;
      hi_timer_q  <= {HI_W{1'b0}};
      gap_timer_q <= {GAP_W{1'b0}};
      coin_q      <= 3'd0;
      enable_q    <= 1'b0;
      reject_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      count_q     <= count_d;
      hi_timer_q  <= hi_timer_d;
      gap_timer_q <= gap_timer_d;
      coin_q      <= coin_d;
      enable_q    <= enable_d;
      reject_q    <= reject_d;
      busy_q      <= busy_d;
    end
  end

  assign Coin   = coin_q;
  assign Enable = enable_q;
  assign Reject = reject_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_coin_pulse_encoder.sv
// Bench for coin_pulse_encoder: vector table, hand-written corner sequences and
// randomized coin groups checked against a pulse-count event model.
module tb_coin_pulse_encoder;
  localparam int DB    = 2;
  localparam int GAP   = 8;
  localparam int STUCK = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin;
  logic [2:0] coin;
  logic       en, rej, busy;

  always #5 clk = ~clk;

  coin_pulse_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .GAP_CYCLES(GAP),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .Pulse_In(pin),
    .Coin(coin),
    .Enable(en),
    .Reject(rej),
    .Busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int rej_cnt  = 0;
  logic [2:0] en_coin  = 3'd0;
  logic [2:0] rej_coin = 3'd0;
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];

  typedef struct {
    int         n;
    int         hi;
    int         lo;
    bit         glitch;
    int         exp_en;
    int         exp_rej;
    logic [2:0] exp_coin;
  } vec_t;

  vec_t vecs[8];
  int   pick[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_group(input int n, input int hi, input int lo, input bit glitch);
    for (int p = 0; p < n; p++) begin
      pin = 1'b1;
      tick(hi);
      pin = 1'b0;
      if (glitch && (p < n - 1)) begin
        tick(lo);
        pin = 1'b1;
        tick(1);
        pin = 1'b0;
      end
      tick(lo);
    end
  endtask

  // Strobe monitor: records every Enable/Reject with the Coin seen during it.
  always @(negedge clk) begin
    if (en || rej) begin
      chk("strobe_exclusive", {31'd0, en & rej}, 32'd0);
      if (en) begin
        en_cnt++;
        en_coin = coin;
        obs_q.push_back({1'b0, coin});
      end
      if (rej) begin
        rej_cnt++;
        rej_coin = coin;
        obs_q.push_back({1'b1, coin});
      end
    end
  end

  initial begin
    int         busy_low;
    int         n, sat, r, npre;
    logic [2:0] held;

    vecs[0] = '{1,  6, 6, 1'b0, 1, 0, 3'b001};
    vecs[1] = '{5,  6, 4, 1'b0, 1, 0, 3'b101};
    vecs[2] = '{1,  6, 6, 1'b0, 1, 0, 3'b001};
    vecs[3] = '{3,  6, 4, 1'b0, 0, 1, 3'b001};
    vecs[4] = '{10, 4, 3, 1'b1, 0, 1, 3'b001};
    vecs[5] = '{5,  2, 2, 1'b0, 1, 0, 3'b101};
    vecs[6] = '{5,  5, 7, 1'b0, 1, 0, 3'b101};
    vecs[7] = '{1, 12, 6, 1'b0, 1, 0, 3'b001};
    pick    = '{1, 5, 1, 5, 2, 3, 4, 6, 7, 9};

    rst = 1'b1;
    pin = 1'b0;
    tick(3);
    chk("reset_coin", coin, 32'd0);
    chk("reset_enable", en, 32'd0);
    chk("reset_reject", rej, 32'd0);
    chk("reset_busy", busy, 32'd0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 8; i++) begin
      en_cnt  = 0;
      rej_cnt = 0;
      apply_group(vecs[i].n, vecs[i].hi, vecs[i].lo, vecs[i].glitch);
      tick(40);
      chk($sformatf("vec%0d_enable_count", i), en_cnt, vecs[i].exp_en);
      chk($sformatf("vec%0d_reject_count", i), rej_cnt, vecs[i].exp_rej);
      chk($sformatf("vec%0d_coin", i), coin, {29'd0, vecs[i].exp_coin});
      if (vecs[i].exp_en > 0) begin
        chk($sformatf("vec%0d_coin_at_enable", i), en_coin, {29'd0, vecs[i].exp_coin});
      end
    end

    tick(100);
    chk("coin_hold_100", coin, 32'd1);
    chk("idle_busy", busy, 32'd0);

    // Stuck input after a 5-peso coin.
    apply_group(5, 6, 4, 1'b0);
    tick(40);
    en_cnt   = 0;
    rej_cnt  = 0;
    busy_low = 0;
    pin = 1'b1;
    tick(6);
    for (int c = 0; c < 34; c++) begin
      if (!busy) busy_low++;
      tick(1);
    end
    chk("stuck_reject_count", rej_cnt, 32'd1);
    chk("stuck_busy_held", busy_low, 32'd0);
    chk("stuck_coin_kept", rej_coin, 32'd5);
    pin = 1'b0;
    tick(10);
    chk("stuck_release_busy", busy, 32'd0);
    chk("stuck_enable_count", en_cnt, 32'd0);
    apply_group(1, 6, 6, 1'b0);
    tick(40);
    chk("after_stuck_enable", en_cnt, 32'd1);
    chk("after_stuck_coin", coin, 32'd1);

    // Reset after the 3rd of 5 pulses.
    en_cnt  = 0;
    rej_cnt = 0;
    apply_group(3, 6, 4, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("midreset_coin", coin, 32'd0);
    chk("midreset_enable", en, 32'd0);
    chk("midreset_reject", rej, 32'd0);
    chk("midreset_busy", busy, 32'd0);
    rst = 1'b0;
    apply_group(2, 6, 4, 1'b0);
    tick(40);
    chk("midreset_reject_count", rej_cnt, 32'd1);
    chk("midreset_enable_count", en_cnt, 32'd0);

    // Randomized coin groups against the pulse-count model.
    held = 3'b000;
    obs_q.delete();
    exp_q.delete();
    for (int g = 0; g < 30; g++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        npre = $urandom_range(0, 3);
        for (int p = 0; p < npre; p++) begin
          pin = 1'b1;
          tick($urandom_range(2, 10));
          pin = 1'b0;
          tick($urandom_range(2, 6));
        end
        pin = 1'b1;
        tick($urandom_range(30, 40));
        pin = 1'b0;
        tick(20);
        exp_q.push_back({1'b1, held});
      end else begin
        n = pick[$urandom_range(0, 9)];
        for (int p = 0; p < n; p++) begin
          pin = 1'b1;
          tick($urandom_range(2, 10));
          pin = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            tick($urandom_range(2, 3));
            pin = 1'b1;
            tick(1);
            pin = 1'b0;
            tick($urandom_range(2, 3));
          end else begin
            tick($urandom_range(2, 6));
          end
        end
        tick(20);
        sat = (n > 7) ? 7 : n;
        if ((sat == 1) || (sat == 5)) begin
          held = 3'(sat);
          exp_q.push_back({1'b0, held});
        end else begin
          exp_q.push_back({1'b1, held});
        end
      end
    end
    chk("rand_event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("rand_event_%0d", i), obs_q[i], exp_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
